simd_alu: RTL

Parametrised, pipelined multi-lane ALU for the SIMD datapath. It executes the processor opcode set on `LANES` independent lanes of `LANE_W` bits each. It adds a cross-lane dot-product reduction with a persistent accumulator and a STOP-driven halt. It sits between the operand register file read ports and the result write-back, with a fixed two-cycle latency for every opcode.

---
 rtl/simd_pkg.sv | 28 ++
 rtl/simd_alu_lane.sv | 44 ++++
 rtl/simd_alu.sv | 120 ++++++++++++
 3 files changed

// File: rtl/simd_pkg.sv
// Shared opcode encoding and lane-slicing helpers for the SIMD ALU.
package simd_pkg;

    localparam int unsigned OP_W = 4;

    typedef enum logic [OP_W-1:0] {
        OpNoop        = 4'd0,
        OpAdd         = 4'd1,
        OpSub         = 4'd2,
        OpMul         = 4'd3,
        OpDotp        = 4'd4,
        OpStoreTempS1 = 4'd5,
        OpStoreTempS2 = 4'd6,
        OpStoreResult = 4'd7,
        OpStop        = 4'd8
    } mode;

    // Bit offset of lane idx in a packed multi-lane bus.
    function automatic int unsigned lane_lo(input int unsigned idx, input int unsigned w);
        return idx * w;
    endfunction

    // Bit offset of the top bit of lane idx.
    function automatic int unsigned lane_hi(input int unsigned idx, input int unsigned w);
        return idx * w + w - 1;
    endfunction

endpackage

// File: rtl/simd_alu_lane.sv
// One SIMD lane: stage-1 registers for sum/carry, difference/borrow and half-width product.
module simd_alu_lane #(
    parameter int unsigned LANE_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [LANE_W-1:0] a,
    input  logic [LANE_W-1:0] b,
    output logic [LANE_W-1:0] sum,
    output logic              carry,
    output logic [LANE_W-1:0] diff,
    output logic              borrow,
    output logic [LANE_W-1:0] prod
);

    localparam int unsigned HALF_W = LANE_W / 2;

    logic [LANE_W:0]   sum_d;
    logic [LANE_W-1:0] prod_d;

    // Lane arithmetic computed combinationally ahead of the stage-1 registers.
    always_comb begin
        sum_d  = {1'b0, a} + {1'b0, b};
        prod_d = LANE_W'(a[HALF_W-1:0]) * LANE_W'(b[HALF_W-1:0]);
    end

    // Stage-1 lane registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum    <= '0;
            carry  <= 1'b0;
            diff   <= '0;
            borrow <= 1'b0;
            prod   <= '0;
        end else begin
            sum    <= sum_d[LANE_W-1:0];
            carry  <= sum_d[LANE_W];
            diff   <= a - b;
            borrow <= (a < b);
            prod   <= prod_d;
        end
    end

endmodule

// File: rtl/simd_alu.sv
// Two-stage multi-lane ALU with dot-product accumulator and STOP-driven halt.
module simd_alu
    import simd_pkg::*;
#(
    parameter int unsigned OPCODE_WIDTH = 4,
    parameter int unsigned LANES        = 4,
    parameter int unsigned LANE_W       = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      valid_in,
    input  logic [OPCODE_WIDTH-1:0]   opcode_in,
    input  logic [LANES*LANE_W-1:0]   a,
    input  logic [LANES*LANE_W-1:0]   b,
    output logic                      valid_out,
    output logic [LANES*LANE_W-1:0]   out,
    output logic [LANES-1:0]          carry_out,
    output logic                      halted
);

    logic                     accept;
    logic                     s1_valid;
    logic [OPCODE_WIDTH-1:0]  s1_op;
    logic [LANES*LANE_W-1:0]  s1_sum;
    logic [LANES*LANE_W-1:0]  s1_diff;
    logic [LANES*LANE_W-1:0]  s1_prod;
    logic [LANES-1:0]         s1_carry;
    logic [LANES-1:0]         s1_borrow;

    logic [LANE_W-1:0]        acc_q, acc_d;
    logic [LANE_W-1:0]        dot;
    logic [LANES*LANE_W-1:0]  res_out;
    logic [LANES-1:0]         res_carry;

    assign accept = valid_in && !halted;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        simd_alu_lane #(
            .LANE_W (LANE_W)
        ) u_lane (
            .clk    (clk),
            .rst    (rst),
            .a      (a[lane_hi(i, LANE_W):lane_lo(i, LANE_W)]),
            .b      (b[lane_hi(i, LANE_W):lane_lo(i, LANE_W)]),
            .sum    (s1_sum[lane_hi(i, LANE_W):lane_lo(i, LANE_W)]),
            .carry  (s1_carry[i]),
            .diff   (s1_diff[lane_hi(i, LANE_W):lane_lo(i, LANE_W)]),
            .borrow (s1_borrow[i]),
            .prod   (s1_prod[lane_hi(i, LANE_W):lane_lo(i, LANE_W)])
        );
    end

    // Stage-1 opcode/valid pipeline and sticky halt flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_op    <= '0;
            halted   <= 1'b0;
        end else begin
            s1_valid <= accept;
            s1_op    <= opcode_in;
            if (accept && opcode_in == OpStop) begin
                halted <= 1'b1;
            end
        end
    end

    // Stage-2 reduction, accumulator update and result selection.
    always_comb begin
        dot       = '0;
        res_out   = '0;
        res_carry = '0;
        acc_d     = acc_q;
        for (int i = 0; i < LANES; i++) begin
            dot = dot + s1_prod[i*LANE_W +: LANE_W];
        end
        if (s1_valid) begin
            case (s1_op)
                OpAdd: begin
                    res_out   = s1_sum;
                    res_carry = s1_carry;
                end
                OpSub: begin
                    res_out   = s1_diff;
                    res_carry = s1_borrow;
                end
                OpMul: begin
                    res_out = s1_prod;
                end
                OpDotp: begin
                    acc_d              = acc_q + dot;
                    res_out[LANE_W-1:0] = acc_d;
                end
                OpStoreResult: begin
                    res_out[LANE_W-1:0] = acc_q;
                    acc_d              = '0;
                end
                default: begin
                    res_out = '0;
                end
            endcase
        end
    end

    // Stage-2 output and accumulator registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_out <= 1'b0;
            out       <= '0;
            carry_out <= '0;
            acc_q     <= '0;
        end else begin
            valid_out <= s1_valid;
            out       <= res_out;
            carry_out <= res_carry;
            acc_q     <= acc_d;
        end
    end

endmodule
